// File: rtl/ex_operand_b_unit.sv
// ex_operand_b_unit
// Execute-stage operand-B unit. It selects ALU operand B from the forwarded rt
// value or one of three immediate forms. It resolves MEM/WB forwarding for rt,
// with MEM taking priority. It flags load-use hazards and registers the results
// in a one-deep EMPTY/FULL stage.
//
// Optional feature: define EX_FWD_STATS_EN to add saturating counters of
// captures that used MEM (o_cnt_fwd_mem) or WB (o_cnt_fwd_wb) forwarding.
module ex_operand_b_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_IMM  = 16,
    parameter int NB_REG  = 5,
    parameter int NB_SEL  = 2,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [NB_SEL-1:0]  i_sel_src,
    input  logic [NB_IMM-1:0]  i_imm,
    input  logic [NB_DATA-1:0] i_rf_data,
    input  logic [NB_REG-1:0]  i_rt_addr,
    input  logic               i_mem_wr_en,
    input  logic [NB_REG-1:0]  i_mem_rd_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic               i_mem_is_load,
    input  logic               i_wb_wr_en,
    input  logic [NB_REG-1:0]  i_wb_rd_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    output logic [NB_DATA-1:0] o_operand_b,
    output logic [NB_DATA-1:0] o_store_data,
    output logic               o_valid,
    output logic [1:0]         o_fwd_sel,
    output logic               o_load_use
`ifdef EX_FWD_STATS_EN
    ,
    output logic [NB_CNT-1:0]  o_cnt_fwd_mem,
    output logic [NB_CNT-1:0]  o_cnt_fwd_wb
`endif
);

    localparam int NB_EXT = NB_DATA - NB_IMM;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_src_t;

    stage_t             state_q;
    fwd_src_t           fwd_q;
    logic [NB_DATA-1:0] operand_b_q;
    logic [NB_DATA-1:0] store_data_q;

    logic               mem_hit;
    logic               wb_hit;
    logic [NB_DATA-1:0] fwd_rt;
    fwd_src_t           fwd_src;
    logic [NB_DATA-1:0] operand_b_d;
    logic               capture;

    // Forwarding match: register 0 is hard-wired zero and never forwarded
    always_comb begin
        mem_hit = i_mem_wr_en && (i_rt_addr != '0) && (i_mem_rd_addr == i_rt_addr);
        wb_hit  = i_wb_wr_en  && (i_rt_addr != '0) && (i_wb_rd_addr  == i_rt_addr);
    end

    // Resolve the rt value: the younger MEM result wins over WB
    always_comb begin
        fwd_rt  = i_rf_data;
        fwd_src = FWD_NONE;
        if (mem_hit) begin
            fwd_rt  = i_mem_data;
            fwd_src = FWD_MEM;
        end else if (wb_hit) begin
            fwd_rt  = i_wb_data;
            fwd_src = FWD_WB;
        end
    end

    // Operand-B source mux; selector values above 3 fall back to rt
    always_comb begin
        operand_b_d = fwd_rt;
        case (i_sel_src)
            NB_SEL'(1): operand_b_d = {{NB_EXT{i_imm[NB_IMM-1]}}, i_imm};
            NB_SEL'(2): operand_b_d = {{NB_EXT{1'b0}}, i_imm};
            NB_SEL'(3): operand_b_d = {i_imm, {NB_EXT{1'b0}}};
            default:    operand_b_d = fwd_rt;
        endcase
    end

    // Load-use hazard: the rt producer is a load still in MEM. Store data
    // always needs rt, so the selector does not mask the hazard.
    always_comb begin
        o_load_use = i_valid && i_mem_is_load && mem_hit;
    end

    assign capture = !i_flush && !i_stall && i_valid && !o_load_use;

    // Stage register: flush > stall > load-use bubble > capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_EMPTY;
            fwd_q        <= FWD_NONE;
            operand_b_q  <= '0;
            store_data_q <= '0;
        end else if (i_flush) begin
            state_q      <= ST_EMPTY;
            fwd_q        <= FWD_NONE;
            operand_b_q  <= '0;
            store_data_q <= '0;
        end else if (i_stall) begin
            state_q      <= state_q;
            fwd_q        <= fwd_q;
            operand_b_q  <= operand_b_q;
            store_data_q <= store_data_q;
        end else if (capture) begin
            state_q      <= ST_FULL;
            fwd_q        <= fwd_src;
            operand_b_q  <= operand_b_d;
            store_data_q <= fwd_rt;
        end else begin
            state_q      <= ST_EMPTY;
            fwd_q        <= FWD_NONE;
            operand_b_q  <= '0;
            store_data_q <= '0;
        end
    end

    assign o_valid      = (state_q == ST_FULL);
    assign o_fwd_sel    = fwd_q;
    assign o_operand_b  = operand_b_q;
    assign o_store_data = store_data_q;

`ifdef EX_FWD_STATS_EN
    logic [NB_CNT-1:0] cnt_mem_q;
    logic [NB_CNT-1:0] cnt_wb_q;

    // Saturating per-source counters, stepped only on a real capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_mem_q <= '0;
            cnt_wb_q  <= '0;
        end else if (capture) begin
            if ((fwd_src == FWD_MEM) && (cnt_mem_q != '1)) begin
                cnt_mem_q <= cnt_mem_q + 1'b1;
            end
            if ((fwd_src == FWD_WB) && (cnt_wb_q != '1)) begin
                cnt_wb_q <= cnt_wb_q + 1'b1;
            end
        end
    end

    assign o_cnt_fwd_mem = cnt_mem_q;
    assign o_cnt_fwd_wb  = cnt_wb_q;
`endif

endmodule

// File: tb/tb_ex_operand_b_unit.sv
// tb_ex_operand_b_unit
// Directed bench for ex_operand_b_unit: a table of single-cycle vectors plus
// hand-written stall, flush, reset and (with EX_FWD_STATS_EN) counter sequences.
module tb_ex_operand_b_unit;

    logic        clk;
    logic        rst_n;
    logic        valid, stall, flush;
    logic [1:0]  sel_src;
    logic [15:0] imm;
    logic [31:0] rf_data;
    logic [4:0]  rt_addr;
    logic        mem_wr_en;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_data;
    logic        mem_is_load;
    logic        wb_wr_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic [31:0] operand_b, store_data;
    logic        out_valid;
    logic [1:0]  fwd_sel;
    logic        load_use;
`ifdef EX_FWD_STATS_EN
    logic [1:0]  cnt_fwd_mem, cnt_fwd_wb;
`endif

    int checks   = 0;
    int failures = 0;

    ex_operand_b_unit #(
        .NB_DATA (32),
        .NB_IMM  (16),
        .NB_REG  (5),
        .NB_SEL  (2),
        .NB_CNT  (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (valid),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_sel_src     (sel_src),
        .i_imm         (imm),
        .i_rf_data     (rf_data),
        .i_rt_addr     (rt_addr),
        .i_mem_wr_en   (mem_wr_en),
        .i_mem_rd_addr (mem_rd_addr),
        .i_mem_data    (mem_data),
        .i_mem_is_load (mem_is_load),
        .i_wb_wr_en    (wb_wr_en),
        .i_wb_rd_addr  (wb_rd_addr),
        .i_wb_data     (wb_data),
        .o_operand_b   (operand_b),
        .o_store_data  (store_data),
        .o_valid       (out_valid),
        .o_fwd_sel     (fwd_sel),
        .o_load_use    (load_use)
`ifdef EX_FWD_STATS_EN
        ,
        .o_cnt_fwd_mem (cnt_fwd_mem),
        .o_cnt_fwd_wb  (cnt_fwd_wb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [31:0] rf;
        logic [4:0]  rt;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        mload;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        exp_lu;
        logic        exp_valid;
        logic [31:0] exp_b;
        logic [31:0] exp_sd;
        logic [1:0]  exp_fwd;
    } vec_t;

    vec_t vecs [0:14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic [31:0] b,
                                 input logic [31:0] sd, input logic [1:0] f);
        chk({tag, ".valid"},      32'(out_valid),  32'(v));
        chk({tag, ".operand_b"},  operand_b,       b);
        chk({tag, ".store_data"}, store_data,      sd);
        chk({tag, ".fwd_sel"},    32'(fwd_sel),    32'(f));
    endtask

    task automatic idle_inputs();
        valid = 1'b0; stall = 1'b0; flush = 1'b0; sel_src = 2'd0; imm = '0;
        rf_data = '0; rt_addr = '0; mem_wr_en = 1'b0; mem_rd_addr = '0;
        mem_data = '0; mem_is_load = 1'b0; wb_wr_en = 1'b0; wb_rd_addr = '0; wb_data = '0;
    endtask

    task automatic apply(input vec_t v);
        valid = v.valid; sel_src = v.sel; imm = v.imm; rf_data = v.rf; rt_addr = v.rt;
        mem_wr_en = v.mwe; mem_rd_addr = v.mrd; mem_data = v.mdata; mem_is_load = v.mload;
        wb_wr_en = v.wwe; wb_rd_addr = v.wrd; wb_data = v.wdata;
    endtask

    // One plain capture: sel=2 zero-extended immediate, rt=3 from the register file
    task automatic capture_imm(input logic [15:0] value);
        @(negedge clk);
        idle_inputs();
        valid = 1'b1; sel_src = 2'd2; imm = value; rt_addr = 5'd3; rf_data = 32'(value);
        @(posedge clk); #1;
    endtask

    initial begin
        //         vld sel imm      rf            rt  mwe mrd  mdata          mld wwe wrd  wdata          lu  ev   exp_b          exp_sd         fwd
        vecs[0]  = '{1'b1, 2'd1, 16'h8000, 32'h0000_0033, 5'd3, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 32'hFFFF_8000, 32'h0000_0033, 2'b00};
        vecs[1]  = '{1'b1, 2'd2, 16'h8000, 32'h0000_0033, 5'd3, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 32'h0000_8000, 32'h0000_0033, 2'b00};
        vecs[2]  = '{1'b1, 2'd3, 16'h8000, 32'h0000_0033, 5'd3, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 32'h8000_0000, 32'h0000_0033, 2'b00};
        vecs[3]  = '{1'b1, 2'd0, 16'h0000, 32'h0000_0BAD, 5'd5, 1'b1, 5'd5, 32'hAAAA_0000, 1'b0, 1'b1, 5'd5, 32'h0000_5555, 1'b0, 1'b1, 32'hAAAA_0000, 32'hAAAA_0000, 2'b10};
        vecs[4]  = '{1'b1, 2'd0, 16'h0000, 32'h0000_0000, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 32'hEEEE_EEEE, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 2'b00};
        vecs[5]  = '{1'b1, 2'd0, 16'h0000, 32'h0000_0BAD, 5'd9, 1'b1, 5'd8, 32'h1111_1111, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b01};
        vecs[6]  = '{1'b1, 2'd0, 16'h0000, 32'h0000_0BAD, 5'd9, 1'b0, 5'd9, 32'h1111_1111, 1'b0, 1'b0, 5'd9, 32'h2222_2222, 1'b0, 1'b1, 32'h0000_0BAD, 32'h0000_0BAD, 2'b00};
        vecs[7]  = '{1'b1, 2'd2, 16'h1234, 32'h0000_0BAD, 5'd9, 1'b1, 5'd9, 32'h1111_1111, 1'b0, 1'b1, 5'd9, 32'h2222_2222, 1'b0, 1'b1, 32'h0000_1234, 32'h1111_1111, 2'b10};
        vecs[8]  = '{1'b0, 2'd1, 16'hFFFF, 32'h0000_0BAD, 5'd9, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00};
        vecs[9]  = '{1'b1, 2'd1, 16'h0001, 32'h0000_0055, 5'd7, 1'b1, 5'd7, 32'h9999_9999, 1'b1, 1'b0, 5'd0, 32'h0,          1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00};
        vecs[10] = '{1'b1, 2'd0, 16'h0000, 32'h0000_0055, 5'd7, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 2'b01};
        vecs[11] = '{1'b1, 2'd1, 16'h7FFF, 32'h0000_0077, 5'd7, 1'b1, 5'd6, 32'h9999_9999, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 32'h0000_7FFF, 32'h0000_0077, 2'b00};
        vecs[12] = '{1'b0, 2'd1, 16'h0000, 32'h0000_0077, 5'd7, 1'b1, 5'd7, 32'h9999_9999, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00};
        vecs[13] = '{1'b1, 2'd2, 16'h00AB, 32'h0000_0000, 5'd0, 1'b1, 5'd0, 32'h9999_9999, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 32'h0000_00AB, 32'h0000_0000, 2'b00};
        vecs[14] = '{1'b1, 2'd0, 16'h0000, 32'h0000_0077, 5'd7, 1'b0, 5'd7, 32'h9999_9999, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 32'h0000_0077, 32'h0000_0077, 2'b00};

        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_outputs("reset", 1'b0, 32'h0, 32'h0, 2'b00);
`ifdef EX_FWD_STATS_EN
        chk("reset.cnt_mem", 32'(cnt_fwd_mem), 32'd0);
        chk("reset.cnt_wb",  32'(cnt_fwd_wb),  32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: drive at negedge, check the hazard flag combinationally,
        // then the registered outputs just after the next rising edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            idle_inputs();
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d.load_use", i), 32'(load_use), 32'(vecs[i].exp_lu));
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_b,
                          vecs[i].exp_sd, vecs[i].exp_fwd);
        end

        // Stall holds a FULL stage for three cycles despite changed inputs,
        // then stall+flush empties it.
        capture_imm(16'h0011);
        check_outputs("stall.load", 1'b1, 32'h11, 32'h11, 2'b00);
        @(negedge clk);
        stall = 1'b1; sel_src = 2'd0; imm = 16'h0099; rt_addr = 5'd5;
        mem_wr_en = 1'b1; mem_rd_addr = 5'd5; mem_data = 32'hCAFE_0000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_outputs($sformatf("stall.hold%0d", c), 1'b1, 32'h11, 32'h11, 2'b00);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check_outputs("stall_flush", 1'b0, 32'h0, 32'h0, 2'b00);

        // Stall while EMPTY keeps it EMPTY even with a valid instruction
        @(negedge clk);
        flush = 1'b0; stall = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        check_outputs("stall_empty", 1'b0, 32'h0, 32'h0, 2'b00);

        // Flush alone from FULL
        capture_imm(16'h0022);
        check_outputs("flush.load", 1'b1, 32'h22, 32'h22, 2'b00);
        @(negedge clk);
        flush = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        check_outputs("flush", 1'b0, 32'h0, 32'h0, 2'b00);

`ifdef EX_FWD_STATS_EN
        // Counters: clear, then MEM captures with stalls/flushes in between
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1; sel_src = 2'd0; rt_addr = 5'd5;
        mem_wr_en = 1'b1; mem_rd_addr = 5'd5; mem_data = 32'h0000_0ABC;
        @(posedge clk); #1;
        chk("cnt.mem1", 32'(cnt_fwd_mem), 32'd1);
        @(negedge clk);
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("cnt.stall", 32'(cnt_fwd_mem), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("cnt.flush", 32'(cnt_fwd_mem), 32'd1);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("cnt.mem_sat", 32'(cnt_fwd_mem), 32'd3);
        chk("cnt.wb_zero", 32'(cnt_fwd_wb),  32'd0);
        @(negedge clk);
        mem_wr_en = 1'b0; wb_wr_en = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'h0000_0DEF;
        @(posedge clk); #1;
        chk("cnt.wb1",     32'(cnt_fwd_wb),  32'd1);
        chk("cnt.mem_hold", 32'(cnt_fwd_mem), 32'd3);
`endif

        // Asynchronous reset mid-stall clears everything without a clock edge
        capture_imm(16'h0011);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 32'h0, 2'b00);
`ifdef EX_FWD_STATS_EN
        chk("async_rst.cnt_mem", 32'(cnt_fwd_mem), 32'd0);
        chk("async_rst.cnt_wb",  32'(cnt_fwd_wb),  32'd0);
`endif
        // First capture happens on the first qualifying edge after release
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        valid = 1'b1; sel_src = 2'd2; imm = 16'h0042; rt_addr = 5'd3; rf_data = 32'h0000_0042;
        @(posedge clk); #1;
        check_outputs("post_rst", 1'b1, 32'h42, 32'h42, 2'b00);

        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        check_outputs("drain", 1'b0, 32'h0, 32'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_b_unit.md
EX_OPERAND_B_UNIT -- requirements
Module: ex_operand_b_unit

Interface
REQ-001 Parameters SHALL be: NB_DATA, default 32, datapath width; NB_IMM, default 16, raw immediate width; NB_REG, default 5, register address width; NB_SEL, default 2, source selector width; NB_CNT, default 16, statistics counter width.
REQ-002 Clock and reset SHALL be: i_clk  input  1  rising-edge clock; i_rst_n  input  1  asynchronous active-low reset.
REQ-003 Inputs SHALL be: i_valid  1  instruction present; i_stall  1  hold stage; i_flush  1  kill stage; i_sel_src  NB_SEL  operand-B source; i_imm  NB_IMM  raw immediate; i_rf_data  NB_DATA  register-file rt value; i_rt_addr  NB_REG  rt address.
REQ-004 Forwarding inputs SHALL be: i_mem_wr_en  1, i_mem_rd_addr  NB_REG, i_mem_data  NB_DATA, i_mem_is_load  1; i_wb_wr_en  1, i_wb_rd_addr  NB_REG, i_wb_data  NB_DATA.
REQ-005 Outputs SHALL be: o_operand_b  NB_DATA  registered ALU operand B; o_store_data  NB_DATA  registered forwarded rt value; o_valid  1  outputs valid; o_fwd_sel  2  registered forward source (00 none, 01 WB, 10 MEM); o_load_use  1  combinational load-use hazard flag.

Function
REQ-006 Selector SHALL map: 0 = forwarded rt, 1 = sign-extended i_imm, 2 = zero-extended i_imm, 3 = i_imm shifted left by NB_DATA-NB_IMM (upper immediate).
REQ-007 Forwarded rt SHALL be i_mem_data if i_mem_wr_en, i_mem_rd_addr==i_rt_addr and i_rt_addr!=0; else i_wb_data under the same conditions for WB; else i_rf_data.
REQ-008 MEM SHALL have priority over WB when both match.
REQ-009 Address 0 SHALL never be forwarded; forwarded rt for i_rt_addr==0 SHALL be i_rf_data.
REQ-010 o_load_use SHALL be 1 when i_valid, i_mem_is_load, i_mem_wr_en, i_rt_addr!=0 and i_mem_rd_addr==i_rt_addr, regardless of i_sel_src (store data depends on rt).
REQ-011 Stage SHALL be a two-state machine: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-012 On each edge, priority SHALL be flush > stall > load-use > capture.
REQ-013 i_flush SHALL force EMPTY and zero all registered outputs next cycle.
REQ-014 i_stall without flush SHALL hold state and all registered outputs unchanged.
REQ-015 i_valid with o_load_use, no stall/flush, SHALL insert a bubble: EMPTY, outputs zeroed.
REQ-016 i_valid without hazard, stall or flush SHALL capture both computed values and o_fwd_sel, entering FULL; latency SHALL be one cycle.
REQ-017 i_valid=0, no stall/flush, SHALL enter EMPTY with outputs zeroed.
REQ-018 o_store_data SHALL always carry the forwarded rt value, independent of i_sel_src.

Reset
REQ-019 i_rst_n low SHALL immediately force EMPTY, o_valid=0, o_operand_b=0, o_store_data=0, o_fwd_sel=00, counters=0, including mid-stall.
REQ-020 First capture after reset release SHALL occur on the first qualifying rising edge with i_rst_n high.

Configuration
REQ-021 Macro EX_FWD_STATS_EN defined SHALL add outputs o_cnt_fwd_mem and o_cnt_fwd_wb (NB_CNT each), incremented once per capture with that forward source, saturating at all-ones, not incremented on stall/flush/bubble.
REQ-022 Macro EX_FWD_STATS_EN undefined SHALL remove those ports and counter logic entirely; all other behaviour SHALL be identical.

Verification
REQ-023 Sel=1, i_imm=0x8000, valid -> next cycle o_operand_b=0xFFFF8000, o_valid=1; sel=2 -> 0x00008000; sel=3 -> 0x80000000.
REQ-024 Sel=0, rt=5, MEM rd=5 data 0xAAAA0000, WB rd=5 data 0x5555 -> o_operand_b=o_store_data=0xAAAA0000, o_fwd_sel=10.
REQ-025 rt=0, MEM and WB rd=0 enabled, i_rf_data=0 -> o_operand_b=0, o_fwd_sel=00.
REQ-026 MEM load rd=7, rt=7, sel=1 -> o_load_use=1, next cycle o_valid=0; following cycle WB rd=7 data 0x1234, sel=0 -> o_store_data=0x1234, o_fwd_sel=01.
REQ-027 FULL with 0x11, stall 3 cycles with changed inputs -> outputs stay 0x11; stall+flush -> o_valid=0, outputs 0.
REQ-028 With EX_FWD_STATS_EN and NB_CNT=2, five MEM-forward captures -> o_cnt_fwd_mem=3; async reset pulse mid-stall -> all outputs 0 immediately.
